// File: rtl/pkt_src_arbiter_if.sv
// Multi-lane Avalon-ST bundle: LANES parallel packet streams sharing one set of wires.
// master drives the beat fields and samples ready; slave does the reverse.
interface pkt_src_arbiter_if #(
  parameter int LANES   = 1,
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
);
  logic [LANES-1:0]         valid;
  logic [LANES-1:0]         sop;
  logic [LANES-1:0]         eop;
  logic [LANES*DATA_W-1:0]  data;
  logic [LANES*EMPTY_W-1:0] empty;
  logic [LANES-1:0]         error;
  logic [LANES-1:0]         ready;

  modport master (
    output valid, sop, eop, data, empty, error,
    input  ready
  );

  modport slave (
    input  valid, sop, eop, data, empty, error,
    output ready
  );
endinterface

// File: rtl/pkt_src_arbiter.sv
// Packet-level round-robin arbiter: holds a grant from SOP through EOP, zero-latency pass-through.
// Orphan beats (valid without SOP) are discarded while idle; non-granted sources stall in PKT.
module pkt_src_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3,
  localparam int SRC_W  = $clog2(NUM_SRC)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arb_enable,
  input  logic              stat_clr,
  pkt_src_arbiter_if.slave  i_src,
  pkt_src_arbiter_if.master o_pkt,
  output logic [SRC_W-1:0]  out_src,
  output logic              busy,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic              sop_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SRC_W-1:0]   r_gnt;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic               r_first;
  logic [31:0]        r_pkt_cnt;
  logic [15:0]        r_drop_cnt;
  logic               r_sop_err;

  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_orphan;
  logic [SRC_W-1:0]   w_pick;
  logic               w_pick_vld;
  logic [SRC_W-1:0]   w_idx;
  logic               w_grant;
  logic               w_acc;
  logic               w_drop_evt;

  logic [NUM_SRC-1:0] w_in_ready;
  logic               w_out_valid;
  logic               w_out_sop;
  logic               w_out_eop;
  logic [DATA_W-1:0]  w_out_data;
  logic [EMPTY_W-1:0] w_out_empty;
  logic               w_out_error;

  assign w_req    = i_src.valid & i_src.sop;
  assign w_orphan = i_src.valid & ~i_src.sop;

  // Cyclic search starting just after the last winner.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_idx      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_pick_vld && w_req[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = '0;
    w_out_valid = 1'b0;
    w_out_sop   = 1'b0;
    w_out_eop   = 1'b0;
    w_out_data  = '0;
    w_out_empty = '0;
    w_out_error = 1'b0;
    w_grant     = 1'b0;
    w_acc       = 1'b0;
    w_drop_evt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = w_orphan;
        w_drop_evt = |w_orphan;
        if (arb_enable && w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = S_PKT;
        end
      end
      S_PKT: begin
        w_out_valid       = i_src.valid[r_gnt];
        w_out_sop         = i_src.sop[r_gnt];
        w_out_eop         = i_src.eop[r_gnt];
        w_out_data        = i_src.data[int'(r_gnt)*DATA_W +: DATA_W];
        w_out_empty       = i_src.empty[int'(r_gnt)*EMPTY_W +: EMPTY_W];
        w_out_error       = i_src.error[r_gnt];
        w_in_ready[r_gnt] = o_pkt.ready[0];
        w_acc             = w_out_valid & o_pkt.ready[0];
        if (w_acc && w_out_eop) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Nothing is offered or consumed while reset is being sampled.
    if (!reset_n) begin
      w_in_ready  = '0;
      w_out_valid = 1'b0;
      w_grant     = 1'b0;
      w_acc       = 1'b0;
      w_drop_evt  = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_gnt      <= '0;
      r_rr_ptr   <= SRC_W'(NUM_SRC - 1);
      r_first    <= 1'b0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_sop_err  <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt    <= w_pick;
        r_rr_ptr <= w_pick;
        r_first  <= 1'b1;
      end else if (w_acc) begin
        r_first  <= 1'b0;
      end

      if (stat_clr) begin
        r_pkt_cnt <= '0;
      end else if (w_acc && w_out_eop) begin
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      end

      if (stat_clr) begin
        r_drop_cnt <= '0;
      end else if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end

      // A SOP on any beat after the first accepted one marks a framing error.
      if (stat_clr) begin
        r_sop_err <= 1'b0;
      end else if (w_acc && w_out_sop && !r_first) begin
        r_sop_err <= 1'b1;
      end
    end
  end

  assign i_src.ready = w_in_ready;
  assign o_pkt.valid = w_out_valid;
  assign o_pkt.sop   = w_out_sop;
  assign o_pkt.eop   = w_out_eop;
  assign o_pkt.data  = w_out_data;
  assign o_pkt.empty = w_out_empty;
  assign o_pkt.error = w_out_error;

  assign out_src  = r_gnt;
  assign busy     = (r_state == S_PKT);
  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
  assign sop_err  = r_sop_err;

endmodule

// File: tb/tb_pkt_src_arbiter.sv
// Randomized and directed bench: per-source beat queues feed the DUT; a packet-level
// round-robin model fills an expected-beat queue that a monitor drains on every accepted beat.
module tb_pkt_src_arbiter;
  localparam int NS = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arb_enable = 1'b1;
  logic          stat_clr = 1'b0;
  logic [SW-1:0] out_src;
  logic          busy;
  logic [31:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
  logic          sop_err;

  pkt_src_arbiter_if #(.LANES(NS), .DATA_W(DW), .EMPTY_W(EW)) src_if ();
  pkt_src_arbiter_if #(.LANES(1),  .DATA_W(DW), .EMPTY_W(EW)) par_if ();

  pkt_src_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .EMPTY_W(EW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .arb_enable (arb_enable),
    .stat_clr   (stat_clr),
    .i_src      (src_if),
    .o_pkt      (par_if),
    .out_src    (out_src),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .sop_err    (sop_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic          error;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] src;
    beat_t         b;
  } exp_t;

  beat_t    lq[NS][$];
  beat_t    mq[NS][$];
  exp_t     expq[$];
  logic [NS-1:0] hold_orphan = '0;
  bit       bub_en = 1'b0;
  bit       gap_chk = 1'b0;
  int       m_last = NS - 1;
  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       last_eop = -1;
  int       last_acc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit lanes_busy();
    bit r = 1'b0;
    for (int s = 0; s < NS; s++) if (lq[s].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic add_pkt(input int s, input int n, input int mid);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.data  = {$urandom(), $urandom()};
      b.sop   = (i == 0) || (i == mid);
      b.eop   = (i == n - 1);
      b.empty = b.eop ? EW'($urandom_range(0, 7)) : '0;
      b.error = b.eop && ($urandom_range(0, 7) == 0);
      lq[s].push_back(b);
      mq[s].push_back(b);
    end
  endtask

  // Whole packets leave in round-robin order among sources that still have packets queued.
  task automatic plan();
    bit found;
    do begin
      found = 1'b0;
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (m_last + k) % NS;
        if (!found && mq[s].size() > 0) begin
          bit done;
          found  = 1'b1;
          m_last = s;
          done   = 1'b0;
          while (!done) begin
            beat_t b;
            exp_t  e;
            b     = mq[s].pop_front();
            e.src = SW'(s);
            e.b   = b;
            expq.push_back(e);
            done  = b.eop;
          end
        end
      end
    end while (found);
  endtask

  task automatic drain(input string name, input int budget, input bit rnd);
    int n = 0;
    while ((expq.size() != 0 || lanes_busy()) && n < budget) begin
      @(posedge clk);
      #1;
      if (rnd) par_if.ready[0] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    par_if.ready[0] = 1'b1;
    checks++;
    if (expq.size() != 0 || lanes_busy()) begin
      errors++;
      $display("FAIL %s: %0d beats still expected after %0d cycles, required 0", name, expq.size(), n);
    end
  endtask

  task automatic wait_busy(input string name, input bit lvl, input int budget);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(busy), 64'(lvl));
  endtask

  // Source driver: pop heads accepted in the previous cycle, then present the next beats.
  initial begin
    logic [NS-1:0]    acc;
    logic [NS-1:0]    v, sp, ep, er;
    logic [NS*DW-1:0] d;
    logic [NS*EW-1:0] em;
    src_if.valid = '0; src_if.sop = '0; src_if.eop = '0;
    src_if.data = '0; src_if.empty = '0; src_if.error = '0;
    forever begin
      @(negedge clk);
      acc = src_if.valid & src_if.ready;
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) begin
        beat_t h;
        if (acc[s] && !hold_orphan[s] && lq[s].size() > 0) void'(lq[s].pop_front());
        v[s] = 1'b0; sp[s] = 1'b0; ep[s] = 1'b0; er[s] = 1'b0;
        d[s*DW +: DW] = '0; em[s*EW +: EW] = '0;
        if (hold_orphan[s]) begin
          v[s] = 1'b1;
          d[s*DW +: DW] = {$urandom(), $urandom()};
        end else if (lq[s].size() > 0) begin
          h = lq[s][0];
          v[s]  = !(bub_en && !h.sop && ($urandom_range(0, 3) == 0));
          sp[s] = h.sop;
          ep[s] = h.eop;
          er[s] = h.error;
          d[s*DW +: DW]  = h.data;
          em[s*EW +: EW] = h.empty;
        end
      end
      src_if.valid = v; src_if.sop = sp; src_if.eop = ep;
      src_if.data = d; src_if.empty = em; src_if.error = er;
    end
  end

  // Monitor: every accepted output beat must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && par_if.valid[0] && par_if.ready[0]) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: src %0d data %0h accepted, required none", out_src, par_if.data);
        end else begin
          e = expq.pop_front();
          chk("beat_data", par_if.data, e.b.data);
          chk("beat_ctl", {out_src, par_if.sop, par_if.eop, par_if.empty, par_if.error},
              {e.src, e.b.sop, e.b.eop, e.b.empty, e.b.error});
        end
        if (gap_chk) begin
          if (par_if.sop[0] && last_eop >= 0) chk("inter_pkt_gap", 64'(cyc - last_eop), 64'd2);
          if (!par_if.sop[0]) chk("contiguous", 64'(cyc - last_acc), 64'd1);
        end
        if (par_if.eop[0]) last_eop = cyc;
        last_acc = cyc;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [63:0] pd;
    bit          pst;
    bit          any;
    par_if.ready = 1'b1;

    // T1: reset with every source asserting valid
    hold_orphan = '1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_out_valid", 64'(par_if.valid), 64'd0);
      chk("t1_in_ready", 64'(src_if.ready), 64'd0);
    end
    chk("t1_cnts", {pkt_cnt, drop_cnt, 15'd0, sop_err}, 64'd0);
    hold_orphan = '0;
    @(posedge clk); #2; reset_n = 1'b1;
    @(negedge clk);
    chk("t1_post_cnts", {pkt_cnt, drop_cnt, 7'd0, busy, 6'(out_src), sop_err}, 64'd0);

    // T2: fairness, two 3-beat packets per source
    gap_chk = 1'b1; last_eop = -1;
    for (int p = 0; p < 2; p++) for (int s = 0; s < NS; s++) add_pkt(s, 3, -1);
    plan();
    drain("t2_drain", 200, 1'b0);
    gap_chk = 1'b0;
    @(negedge clk);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // T3: backpressure on a 5-beat packet from source 2
    add_pkt(2, 5, -1);
    plan();
    pst = 1'b0; pd = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      par_if.ready[0] = (k % 3 == 0);
      @(negedge clk);
      if (busy) begin
        chk("t3_in_ready", 64'(src_if.ready), par_if.ready[0] ? 64'h4 : 64'h0);
        if (pst) chk("t3_stall_hold", par_if.data, pd);
      end
      pst = busy && par_if.valid[0] && !par_if.ready[0];
      pd  = par_if.data;
    end
    drain("t3_drain", 50, 1'b0);
    @(negedge clk);
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd9);

    // T4: orphans on source 1, then a real packet, then saturation
    hold_orphan[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t4_orphan_ready", 64'(src_if.ready), 64'h2);
    end
    hold_orphan[1] = 1'b0;
    @(negedge clk);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd4);
    add_pkt(1, 2, -1);
    plan();
    drain("t4_drain", 50, 1'b0);
    hold_orphan[1] = 1'b1;
    repeat (70000) @(negedge clk);
    hold_orphan[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_drop_sat", 64'(drop_cnt), 64'hFFFF);

    // T5: mid-packet SOP and a single-beat packet, then stat_clr
    chk("t5_sop_err_pre", 64'(sop_err), 64'd0);
    add_pkt(0, 4, 2);
    add_pkt(3, 1, -1);
    plan();
    drain("t5_drain", 60, 1'b0);
    @(negedge clk);
    chk("t5_sop_err", 64'(sop_err), 64'd1);
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd12);
    hold_orphan[2] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; stat_clr = 1'b1;
    @(negedge clk); hold_orphan[2] = 1'b0;
    @(posedge clk); #1; stat_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_pkt", 64'(pkt_cnt), 64'd0);
    chk("t5_clr_drop", 64'(drop_cnt), 64'd0);
    chk("t5_clr_err", 64'(sop_err), 64'd0);

    // Randomized rounds with source bubbles and random backpressure
    bub_en = 1'b1;
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < NS; s++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 6), -1);
      end
      plan();
      drain("rand_drain", 600, 1'b1);
    end
    bub_en = 1'b0;
    chk("rand_sop_err", 64'(sop_err), 64'd0);

    // T6a: arb_enable dropped mid-packet
    add_pkt(0, 4, -1);
    add_pkt(1, 3, -1);
    plan();
    wait_busy("t6_first_grant", 1'b1, 20);
    @(posedge clk); #1; arb_enable = 1'b0;
    wait_busy("t6_pkt_done", 1'b0, 20);
    any = 1'b0;
    repeat (8) begin
      @(negedge clk);
      any = any | busy | par_if.valid[0];
    end
    chk("t6_no_new_grant", 64'(any), 64'd0);
    chk("t6_pending", 64'(expq.size() > 0), 64'd1);
    arb_enable = 1'b1;
    drain("t6_drain", 50, 1'b0);

    // T6b: reset in the middle of a packet
    add_pkt(2, 6, -1);
    plan();
    wait_busy("t6_rst_grant", 1'b1, 20);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    for (int s = 0; s < NS; s++) begin
      lq[s].delete();
      mq[s].delete();
    end
    expq.delete();
    m_last = NS - 1;
    @(negedge clk);
    @(posedge clk); #2; reset_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_out_valid", 64'(par_if.valid), 64'd0);
    chk("t6_rst_idle", 64'(busy), 64'd0);
    add_pkt(1, 2, -1);
    add_pkt(0, 2, -1);
    plan();
    wait_busy("t6_rearb", 1'b1, 20);
    chk("t6_src0_wins", 64'(out_src), 64'd0);
    drain("t6_rst_drain", 50, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
